rotary_decoder_mc: RTL and testbench
====================================

ROTARY_DECODER_MC -- requirements
Module: rotary_decoder_mc

Interface
REQ-001 SHALL have parameter CH, default 2, number of independent encoder channels (1..8).
REQ-002 SHALL have parameter DB_N, default 11, debounce counter width; input must be stable 2^DB_N cycles to be accepted.
REQ-003 SHALL have parameter POS_W, default 8, width of each position counter.
REQ-004 SHALL have parameter POS_MAX, default 2^POS_W-1, upper position bound (lower bound 0).
REQ-005 SHALL have parameter WRAP, default 1; 1 = wrap at bounds, 0 = saturate.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 reset_n  input  1  reset, synchronous, active-low.
REQ-008 enable  input  1  decoding enable, shared by all channels.
REQ-009 mode  input  1  0 = x1 (one step per full detent cycle), 1 = x4 (one step per legal edge).
REQ-010 a, b  input  CH each  raw asynchronous quadrature inputs, bit i = channel i.
REQ-011 clear  input  CH  synchronous per-channel position/error clear.
REQ-012 right, left  output  CH each  one-cycle step pulses per channel.
REQ-013 pos  output  CH*POS_W  packed positions, channel i at bits [i*POS_W +: POS_W].
REQ-014 err  output  CH  sticky illegal-transition flag per channel.

Function
REQ-015 Each a/b bit SHALL pass a 2-FF synchronizer, then a debouncer whose level changes only after the synchronized input differs from it for 2^DB_N consecutive cycles.
REQ-016 Channel state SHALL be {A,B} of debounced levels; forward (right) sequence 00->01->11->10->00, reverse the opposite.
REQ-017 Each channel SHALL hold prev state and a primed bit; the first debounced-stable sample after reset or enable rising SHALL load prev and set primed without step or error.
REQ-018 In mode 1, every legal forward/reverse single-bit transition SHALL pulse right/left respectively.
REQ-019 In mode 0, only 10->00 SHALL pulse right and only 01->00 SHALL pulse left; other legal transitions update prev only.
REQ-020 A transition changing both bits SHALL set err, produce no pulse, no pos change, and load prev.
REQ-021 Pulses SHALL be registered, exactly one cycle wide, asserted the cycle after the debounced level changes.
REQ-022 pos SHALL increment on right, decrement on left, in the same cycle the pulse is asserted.
REQ-023 At POS_MAX increment SHALL give 0 (WRAP=1) or hold POS_MAX (WRAP=0); at 0 decrement SHALL give POS_MAX or hold 0.
REQ-024 clear[i] SHALL zero pos[i] and err[i] next cycle, overriding a simultaneous step; the pulse still fires.
REQ-025 enable low SHALL force right/left to 0, hold pos and err, clear primed; debouncers keep running.
REQ-026 mode change mid-rotation SHALL take effect on the next transition with no pulse for the change itself.
REQ-027 Channels SHALL be fully independent; simultaneous steps on all channels SHALL all be reported.

Reset
REQ-028 reset_n low at a clock edge SHALL set right, left, err, pos, primed, prev, synchronizers and debounced levels to 0 and debounce counters to 0, including mid-rotation.

Structure
REQ-029 Package rotary_pkg SHALL hold mode constants (MODE_X1, MODE_X4) and the 2-bit quadrature state encodings.
REQ-030 Per-channel logic (sync, debounce, decode, counter) SHALL be one sub-module quad_channel, instantiated CH times by generate.

Verification (bench uses CH=2, DB_N=3, POS_W=4, POS_MAX=9)
REQ-031 Mode 1, ch0 driven 00->01->11->10->00, each held 20 cycles -> 4 right pulses, pos0=4, pos1=0, err=0.
REQ-032 Mode 0, same sequence then reverse 00->01->00 ... full reverse cycle -> one right then one left, pos0 returns 0.
REQ-033 Glitch of 5 cycles on a0 -> no pulse, pos unchanged; WRAP=1 with pos0=9 plus one x4 step -> pos0=0; WRAP=0 -> stays 9.
REQ-034 ch1 jump 00->11 -> err[1]=1, no pulse; clear[1] asserted same cycle as a subsequent step -> pos1=0, err[1]=0.
REQ-035 enable low during rotation for 3 transitions, then high -> no pulses while low, no spurious pulse on re-enable; reset_n low mid-rotation -> all outputs 0 next cycle.

Source files
------------

// File: rtl/rotary_pkg.sv
// Shared constants for the multi-channel quadrature decoder: count modes,
// the 2-bit {A,B} state encodings and direction helpers.
package rotary_pkg;

    localparam logic MODE_X1 = 1'b0;
    localparam logic MODE_X4 = 1'b1;

    localparam logic [1:0] QS_00 = 2'b00;
    localparam logic [1:0] QS_01 = 2'b01;
    localparam logic [1:0] QS_11 = 2'b11;
    localparam logic [1:0] QS_10 = 2'b10;

    // Forward rotation walks 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic is_fwd(input logic [1:0] prev_s, input logic [1:0] cur_s);
        return ((prev_s == QS_00) && (cur_s == QS_01)) ||
               ((prev_s == QS_01) && (cur_s == QS_11)) ||
               ((prev_s == QS_11) && (cur_s == QS_10)) ||
               ((prev_s == QS_10) && (cur_s == QS_00));
    endfunction

    function automatic logic is_rev(input logic [1:0] prev_s, input logic [1:0] cur_s);
        return is_fwd(cur_s, prev_s);
    endfunction

endpackage

// File: rtl/quad_channel.sv
// One encoder channel: 2-FF synchronizers, debouncers, quadrature decode,
// registered step pulses and a bounded position counter with sticky error.
module quad_channel
    import rotary_pkg::*;
#(
    parameter int DB_N    = 11,
    parameter int POS_W   = 8,
    parameter int POS_MAX = (1 << POS_W) - 1,
    parameter int WRAP    = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             mode,
    input  logic             a,
    input  logic             b,
    input  logic             clear,
    output logic             right,
    output logic             left,
    output logic [POS_W-1:0] pos,
    output logic             err
);

    localparam logic [POS_W-1:0] PMAX  = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] PZERO = '0;

    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      db;
    logic [DB_N-1:0] db_cnt [2];

    logic [1:0] prev;
    logic       primed;
    logic       active;
    logic       changed;
    logic       illegal;
    logic       step_r;
    logic       step_l;

    // Bit 1 carries A, bit 0 carries B, so db is directly the {A,B} state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= {a, b};
            sync2 <= sync1;
        end
    end

    // A level is accepted only after 2^DB_N consecutive differing samples.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            db <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != db[i]) begin
                    if (&db_cnt[i]) begin
                        db[i]     <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_N'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign active  = enable && primed;
    assign changed = (db != prev);
    assign illegal = active && ((db ^ prev) == 2'b11);

    always_comb begin
        step_r = 1'b0;
        step_l = 1'b0;
        if (active && changed && !illegal) begin
            if (mode == MODE_X4) begin
                step_r = is_fwd(prev, db);
                step_l = is_rev(prev, db);
            end else begin
                step_r = (prev == QS_10) && (db == QS_00);
                step_l = (prev == QS_01) && (db == QS_00);
            end
        end
    end

    function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] p);
        if (p == PMAX) begin
            return (WRAP != 0) ? PZERO : PMAX;
        end
        return p + POS_W'(1);
    endfunction

    function automatic logic [POS_W-1:0] pos_dec(input logic [POS_W-1:0] p);
        if (p == PZERO) begin
            return (WRAP != 0) ? PMAX : PZERO;
        end
        return p - POS_W'(1);
    endfunction

    // Dropping enable un-primes the channel so re-enabling just re-learns prev.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev   <= 2'b00;
            primed <= 1'b0;
            right  <= 1'b0;
            left   <= 1'b0;
            pos    <= '0;
            err    <= 1'b0;
        end else begin
            right <= step_r;
            left  <= step_l;

            if (!enable) begin
                primed <= 1'b0;
            end else if (!primed) begin
                prev   <= db;
                primed <= 1'b1;
            end else if (changed) begin
                prev <= db;
            end

            if (clear) begin
                pos <= '0;
                err <= 1'b0;
            end else begin
                if (illegal) begin
                    err <= 1'b1;
                end
                if (step_r) begin
                    pos <= pos_inc(pos);
                end else if (step_l) begin
                    pos <= pos_dec(pos);
                end
            end
        end
    end

endmodule

// File: rtl/rotary_decoder_mc.sv
// Multi-channel rotary encoder decoder: CH independent quad_channel slices
// sharing clock, reset, enable and count mode.
module rotary_decoder_mc
    import rotary_pkg::*;
#(
    parameter int CH      = 2,
    parameter int DB_N    = 11,
    parameter int POS_W   = 8,
    parameter int POS_MAX = (1 << POS_W) - 1,
    parameter int WRAP    = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                mode,
    input  logic [CH-1:0]       a,
    input  logic [CH-1:0]       b,
    input  logic [CH-1:0]       clear,
    output logic [CH-1:0]       right,
    output logic [CH-1:0]       left,
    output logic [CH*POS_W-1:0] pos,
    output logic [CH-1:0]       err
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        quad_channel #(
            .DB_N    (DB_N),
            .POS_W   (POS_W),
            .POS_MAX (POS_MAX),
            .WRAP    (WRAP)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .enable  (enable),
            .mode    (mode),
            .a       (a[i]),
            .b       (b[i]),
            .clear   (clear[i]),
            .right   (right[i]),
            .left    (left[i]),
            .pos     (pos[i*POS_W +: POS_W]),
            .err     (err[i])
        );
    end

endmodule

// File: tb/tb_rotary_decoder_mc.sv
// Directed bench for rotary_decoder_mc: a wrapping and a saturating instance
// share every input; pulses are tallied on the falling clock edge.
module tb_rotary_decoder_mc;

    localparam int CH      = 2;
    localparam int DB_N    = 3;
    localparam int POS_W   = 4;
    localparam int POS_MAX = 9;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                enable;
    logic                mode;
    logic [CH-1:0]       a;
    logic [CH-1:0]       b;
    logic [CH-1:0]       clear;
    logic [CH-1:0]       right;
    logic [CH-1:0]       left;
    logic [CH*POS_W-1:0] pos;
    logic [CH-1:0]       err;
    logic [CH-1:0]       right_s;
    logic [CH-1:0]       left_s;
    logic [CH*POS_W-1:0] pos_s;
    logic [CH-1:0]       err_s;

    int checks   = 0;
    int failures = 0;
    int r0, l0, r1, l1;

    always #5 clk = ~clk;

    rotary_decoder_mc #(
        .CH(CH), .DB_N(DB_N), .POS_W(POS_W), .POS_MAX(POS_MAX), .WRAP(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
        .a(a), .b(b), .clear(clear),
        .right(right), .left(left), .pos(pos), .err(err)
    );

    rotary_decoder_mc #(
        .CH(CH), .DB_N(DB_N), .POS_W(POS_W), .POS_MAX(POS_MAX), .WRAP(0)
    ) dut_sat (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
        .a(a), .b(b), .clear(clear),
        .right(right_s), .left(left_s), .pos(pos_s), .err(err_s)
    );

    task automatic clear_counts();
        r0 = 0; l0 = 0; r1 = 0; l1 = 0;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            r0 += int'(right[0]);
            l0 += int'(left[0]);
            r1 += int'(right[1]);
            l1 += int'(left[1]);
        end
    endtask

    task automatic step0(input logic [1:0] s);
        a[0] = s[1];
        b[0] = s[0];
        run_cycles(20);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        a = '0; b = '0; clear = '0;
        run_cycles(3);
        reset_n = 1'b1;
        run_cycles(2);
        clear_counts();
    endtask

    task automatic test_reset();
        enable = 1'b1;
        mode   = 1'b1;
        do_reset();
        checks += 4;
        if (right !== 2'b00) begin failures++; $display("[TB] FAIL reset_right got=%b exp=00", right); end
        if (left !== 2'b00) begin failures++; $display("[TB] FAIL reset_left got=%b exp=00", left); end
        if (pos !== 8'h00) begin failures++; $display("[TB] FAIL reset_pos got=%h exp=00", pos); end
        if (err !== 2'b00) begin failures++; $display("[TB] FAIL reset_err got=%b exp=00", err); end
    endtask

    task automatic test_x4();
        mode = 1'b1;
        clear_counts();
        step0(2'b01); step0(2'b11); step0(2'b10); step0(2'b00);
        checks += 5;
        if (r0 !== 4 || l0 !== 0) begin failures++; $display("[TB] FAIL x4_pulses got r=%0d l=%0d exp r=4 l=0", r0, l0); end
        if (pos[3:0] !== 4'd4) begin failures++; $display("[TB] FAIL x4_pos0 got=%0d exp=4", pos[3:0]); end
        if (pos[7:4] !== 4'd0) begin failures++; $display("[TB] FAIL x4_pos1 got=%0d exp=0", pos[7:4]); end
        if (err !== 2'b00) begin failures++; $display("[TB] FAIL x4_err got=%b exp=00", err); end
        if (r1 !== 0 || l1 !== 0) begin failures++; $display("[TB] FAIL x4_ch1_quiet got r=%0d l=%0d exp 0 0", r1, l1); end
    endtask

    task automatic test_x1();
        do_reset();
        mode = 1'b0;
        step0(2'b01); step0(2'b11); step0(2'b10); step0(2'b00);
        checks += 2;
        if (r0 !== 1 || l0 !== 0) begin failures++; $display("[TB] FAIL x1_fwd_pulses got r=%0d l=%0d exp r=1 l=0", r0, l0); end
        if (pos[3:0] !== 4'd1) begin failures++; $display("[TB] FAIL x1_fwd_pos0 got=%0d exp=1", pos[3:0]); end
        clear_counts();
        step0(2'b10); step0(2'b11); step0(2'b01); step0(2'b00);
        checks += 2;
        if (r0 !== 0 || l0 !== 1) begin failures++; $display("[TB] FAIL x1_rev_pulses got r=%0d l=%0d exp r=0 l=1", r0, l0); end
        if (pos[3:0] !== 4'd0) begin failures++; $display("[TB] FAIL x1_rev_pos0 got=%0d exp=0", pos[3:0]); end
    endtask

    task automatic test_glitch();
        mode = 1'b1;
        clear_counts();
        a[0] = 1'b1;
        run_cycles(5);
        a[0] = 1'b0;
        run_cycles(20);
        checks += 2;
        if (r0 !== 0 || l0 !== 0) begin failures++; $display("[TB] FAIL glitch_pulses got r=%0d l=%0d exp 0 0", r0, l0); end
        if (pos[3:0] !== 4'd0) begin failures++; $display("[TB] FAIL glitch_pos0 got=%0d exp=0", pos[3:0]); end
    endtask

    task automatic test_wrap();
        mode = 1'b1;
        step0(2'b01); step0(2'b11); step0(2'b10); step0(2'b00);
        step0(2'b01); step0(2'b11); step0(2'b10); step0(2'b00);
        step0(2'b01);
        checks += 2;
        if (pos[3:0] !== 4'd9) begin failures++; $display("[TB] FAIL wrap_at_max got=%0d exp=9", pos[3:0]); end
        if (pos_s[3:0] !== 4'd9) begin failures++; $display("[TB] FAIL sat_at_max got=%0d exp=9", pos_s[3:0]); end
        step0(2'b11);
        checks += 2;
        if (pos[3:0] !== 4'd0) begin failures++; $display("[TB] FAIL wrap_inc got=%0d exp=0", pos[3:0]); end
        if (pos_s[3:0] !== 4'd9) begin failures++; $display("[TB] FAIL sat_inc got=%0d exp=9", pos_s[3:0]); end
        step0(2'b01);
        checks += 2;
        if (pos[3:0] !== 4'd9) begin failures++; $display("[TB] FAIL wrap_dec got=%0d exp=9", pos[3:0]); end
        if (pos_s[3:0] !== 4'd8) begin failures++; $display("[TB] FAIL sat_dec got=%0d exp=8", pos_s[3:0]); end
    endtask

    task automatic test_error_clear();
        do_reset();
        mode = 1'b1;
        a[1] = 1'b1;
        b[1] = 1'b1;
        run_cycles(20);
        checks += 3;
        if (err !== 2'b10) begin failures++; $display("[TB] FAIL err_jump got=%b exp=10", err); end
        if (r1 !== 0 || l1 !== 0) begin failures++; $display("[TB] FAIL err_no_pulse got r=%0d l=%0d exp 0 0", r1, l1); end
        if (pos[7:4] !== 4'd0) begin failures++; $display("[TB] FAIL err_pos1 got=%0d exp=0", pos[7:4]); end
        // Input change reaches the pulse register on the 11th rising edge.
        b[1] = 1'b0;
        repeat (10) @(negedge clk);
        clear[1] = 1'b1;
        @(negedge clk);
        checks += 3;
        if (right[1] !== 1'b1) begin failures++; $display("[TB] FAIL clear_pulse got=%b exp=1", right[1]); end
        if (pos[7:4] !== 4'd0) begin failures++; $display("[TB] FAIL clear_pos1 got=%0d exp=0", pos[7:4]); end
        if (err[1] !== 1'b0) begin failures++; $display("[TB] FAIL clear_err1 got=%b exp=0", err[1]); end
        clear[1] = 1'b0;
        run_cycles(5);
    endtask

    task automatic test_enable();
        do_reset();
        mode   = 1'b1;
        enable = 1'b0;
        step0(2'b01); step0(2'b11); step0(2'b10);
        checks += 2;
        if (r0 !== 0 || l0 !== 0) begin failures++; $display("[TB] FAIL disabled_pulses got r=%0d l=%0d exp 0 0", r0, l0); end
        if (pos[3:0] !== 4'd0) begin failures++; $display("[TB] FAIL disabled_pos0 got=%0d exp=0", pos[3:0]); end
        enable = 1'b1;
        run_cycles(20);
        checks += 1;
        if (r0 !== 0 || l0 !== 0) begin failures++; $display("[TB] FAIL reenable_pulses got r=%0d l=%0d exp 0 0", r0, l0); end
        step0(2'b00);
        checks += 2;
        if (r0 !== 1) begin failures++; $display("[TB] FAIL resume_pulse got=%0d exp=1", r0); end
        if (pos[3:0] !== 4'd1) begin failures++; $display("[TB] FAIL resume_pos0 got=%0d exp=1", pos[3:0]); end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        a = 2'b00;
        b = 2'b11;
        run_cycles(20);
        checks += 2;
        if (r0 !== 1 || r1 !== 1) begin failures++; $display("[TB] FAIL simul_pulses got r0=%0d r1=%0d exp 1 1", r0, r1); end
        if (pos !== 8'h12) begin failures++; $display("[TB] FAIL simul_pos got=%h exp=12", pos); end
    endtask

    task automatic test_reset_mid();
        a[1] = 1'b1;
        b[1] = 1'b0;
        run_cycles(20);
        checks += 1;
        if (err !== 2'b10) begin failures++; $display("[TB] FAIL mid_err_set got=%b exp=10", err); end
        reset_n = 1'b0;
        @(negedge clk);
        checks += 3;
        if (pos !== 8'h00 || pos_s !== 8'h00) begin failures++; $display("[TB] FAIL mid_reset_pos got=%h/%h exp=00", pos, pos_s); end
        if (err !== 2'b00) begin failures++; $display("[TB] FAIL mid_reset_err got=%b exp=00", err); end
        if (right !== 2'b00 || left !== 2'b00) begin failures++; $display("[TB] FAIL mid_reset_pulse got r=%b l=%b exp 00", right, left); end
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        mode    = 1'b1;
        a       = '0;
        b       = '0;
        clear   = '0;
        clear_counts();
        test_reset();
        test_x4();
        test_x1();
        test_glitch();
        test_wrap();
        test_error_clear();
        test_enable();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
